// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
//
// Two-master AXI read-channel arbiter. One master at a time owns the shared
// AR/R path; ownership is decided round-robin and released on the RLAST
// handshake. The slave-side ARID carries the master index so returned data
// can be attributed. Returned bursts are checked for length and ID, and any
// violation raises a sticky protocol_err.
//
// Ports:
//   ACLK, ARESETn           clock, asynchronous active-low reset
//   M0_AR* / M1_AR*         master read-address channels (ARREADY out)
//   M0_R*  / M1_R*          master read-data channels (RREADY in)
//   S_AR*                   slave read-address channel, S_ARID = {3'b0, grant, ARID}
//   S_R*                    slave read-data channel (S_RREADY out)
//   protocol_err            sticky burst-length / ID mismatch flag
// ---------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // master 0
    input  logic [ID_W-1:0]   M0_ARID,
    input  logic [ADDR_W-1:0] M0_ARADDR,
    input  logic [LEN_W-1:0]  M0_ARLEN,
    input  logic [2:0]        M0_ARSIZE,
    input  logic [1:0]        M0_ARBURST,
    input  logic              M0_ARVALID,
    output logic              M0_ARREADY,
    output logic [ID_W-1:0]   M0_RID,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,
    output logic              M0_RLAST,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,
    // master 1
    input  logic [ID_W-1:0]   M1_ARID,
    input  logic [ADDR_W-1:0] M1_ARADDR,
    input  logic [LEN_W-1:0]  M1_ARLEN,
    input  logic [2:0]        M1_ARSIZE,
    input  logic [1:0]        M1_ARBURST,
    input  logic              M1_ARVALID,
    output logic              M1_ARREADY,
    output logic [ID_W-1:0]   M1_RID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,
    output logic              M1_RLAST,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,
    // slave side
    output logic [ID_W+3:0]   S_ARID,
    output logic [ADDR_W-1:0] S_ARADDR,
    output logic [LEN_W-1:0]  S_ARLEN,
    output logic [2:0]        S_ARSIZE,
    output logic [1:0]        S_ARBURST,
    output logic              S_ARVALID,
    input  logic              S_ARREADY,
    input  logic [ID_W+3:0]   S_RID,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic [1:0]        S_RRESP,
    input  logic              S_RLAST,
    input  logic              S_RVALID,
    output logic              S_RREADY,
    // status
    output logic              protocol_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t             state;
    logic               grant;       // index of the owning master
    logic               prio;        // master preferred on a tie
    logic [ID_W+3:0]    tag_id;      // slave-side ID of the outstanding read
    logic [LEN_W-1:0]   beats_left;  // beats still expected after the current one

    // Granted-master view of the request and of RREADY.
    logic               sel_arvalid;
    logic [ID_W-1:0]    sel_arid;
    logic [ADDR_W-1:0]  sel_araddr;
    logic [LEN_W-1:0]   sel_arlen;
    logic [2:0]         sel_arsize;
    logic [1:0]         sel_arburst;
    logic               sel_rready;
    logic [ID_W+3:0]    ar_tag;
    logic               ar_hs;
    logic               r_hs;
    logic               beat_err;

    assign sel_arvalid = grant ? M1_ARVALID : M0_ARVALID;
    assign sel_arid    = grant ? M1_ARID    : M0_ARID;
    assign sel_araddr  = grant ? M1_ARADDR  : M0_ARADDR;
    assign sel_arlen   = grant ? M1_ARLEN   : M0_ARLEN;
    assign sel_arsize  = grant ? M1_ARSIZE  : M0_ARSIZE;
    assign sel_arburst = grant ? M1_ARBURST : M0_ARBURST;
    assign sel_rready  = grant ? M1_RREADY  : M0_RREADY;
    assign ar_tag      = {3'b000, grant, sel_arid};

    assign ar_hs = (state == ADDR) && sel_arvalid && S_ARREADY;
    assign r_hs  = (state == DATA) && S_RVALID && sel_rready;

    // RLAST must coincide exactly with the final beat, and the returned ID
    // must be the tag issued for this read.
    assign beat_err = (S_RLAST != (beats_left == '0)) || (S_RID != tag_id);

    // Channel routing: everything is pass-through, gated by state and grant.
    always_comb begin
        // NOTE: every output gets a default before the conditional routing so
        // no path leaves a signal unassigned, which would infer a latch.
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        M0_RID     = '0;
        M0_RDATA   = '0;
        M0_RRESP   = '0;
        M0_RLAST   = 1'b0;
        M0_RVALID  = 1'b0;
        M1_RID     = '0;
        M1_RDATA   = '0;
        M1_RRESP   = '0;
        M1_RLAST   = 1'b0;
        M1_RVALID  = 1'b0;
        S_ARID     = '0;
        S_ARADDR   = '0;
        S_ARLEN    = '0;
        S_ARSIZE   = '0;
        S_ARBURST  = '0;
        S_ARVALID  = 1'b0;
        S_RREADY   = 1'b0;

        if (state == ADDR) begin
            S_ARID    = ar_tag;
            S_ARADDR  = sel_araddr;
            S_ARLEN   = sel_arlen;
            S_ARSIZE  = sel_arsize;
            S_ARBURST = sel_arburst;
            S_ARVALID = sel_arvalid;
            if (grant) M1_ARREADY = S_ARREADY;
            else       M0_ARREADY = S_ARREADY;
        end

        if (state == DATA) begin
            S_RREADY = sel_rready;
            if (grant) begin
                M1_RID    = S_RID[ID_W-1:0];
                M1_RDATA  = S_RDATA;
                M1_RRESP  = S_RRESP;
                M1_RLAST  = S_RLAST;
                M1_RVALID = S_RVALID;
            end else begin
                M0_RID    = S_RID[ID_W-1:0];
                M0_RDATA  = S_RDATA;
                M0_RRESP  = S_RRESP;
                M0_RLAST  = S_RLAST;
                M0_RVALID = S_RVALID;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            grant        <= 1'b0;
            prio         <= 1'b0;
            tag_id       <= '0;
            beats_left   <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (M0_ARVALID || M1_ARVALID) begin
                        grant <= (M0_ARVALID && M1_ARVALID) ? prio : M1_ARVALID;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        tag_id     <= ar_tag;
                        beats_left <= sel_arlen;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beats_left != '0) beats_left <= beats_left - LEN_W'(1);
                        if (beat_err) protocol_err <= 1'b1;
                        // A malformed burst still ends on RLAST so the bus recovers.
                        if (S_RLAST) begin
                            prio  <= ~grant;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Directed scenarios followed by a randomized run. Each cycle the DUT outputs
// are compared against a transaction-level reference model (owner, phase,
// beats remaining) that also drives the slave responder.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int TW     = ID_W + 4;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    // master-side stimulus, indexed by master
    logic              m_arvalid [2];
    logic [ID_W-1:0]   m_arid    [2];
    logic [ADDR_W-1:0] m_araddr  [2];
    logic [LEN_W-1:0]  m_arlen   [2];
    logic [2:0]        m_arsize  [2];
    logic [1:0]        m_arburst [2];
    logic              m_rready  [2];

    // slave-side stimulus
    logic              s_arready;
    logic [TW-1:0]     s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;

    // DUT outputs
    logic              m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [ID_W-1:0]   m0_rid, m1_rid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        m0_rresp, m1_rresp;
    logic [TW-1:0]     s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [LEN_W-1:0]  s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arvalid, s_rready, perr;

    axi_read_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARID(m_arid[0]), .M0_ARADDR(m_araddr[0]), .M0_ARLEN(m_arlen[0]),
        .M0_ARSIZE(m_arsize[0]), .M0_ARBURST(m_arburst[0]), .M0_ARVALID(m_arvalid[0]),
        .M0_ARREADY(m0_arready), .M0_RID(m0_rid), .M0_RDATA(m0_rdata), .M0_RRESP(m0_rresp),
        .M0_RLAST(m0_rlast), .M0_RVALID(m0_rvalid), .M0_RREADY(m_rready[0]),
        .M1_ARID(m_arid[1]), .M1_ARADDR(m_araddr[1]), .M1_ARLEN(m_arlen[1]),
        .M1_ARSIZE(m_arsize[1]), .M1_ARBURST(m_arburst[1]), .M1_ARVALID(m_arvalid[1]),
        .M1_ARREADY(m1_arready), .M1_RID(m1_rid), .M1_RDATA(m1_rdata), .M1_RRESP(m1_rresp),
        .M1_RLAST(m1_rlast), .M1_RVALID(m1_rvalid), .M1_RREADY(m_rready[1]),
        .S_ARID(s_arid), .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARSIZE(s_arsize),
        .S_ARBURST(s_arburst), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RID(s_rid), .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RLAST(s_rlast),
        .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .protocol_err(perr)
    );

    // All DUT outputs as one bundle; per-master fields are indexed [m*W +: W].
    typedef struct packed {
        logic [1:0]          arready;
        logic [1:0]          rvalid;
        logic [1:0]          rlast;
        logic [3:0]          rresp;
        logic [2*ID_W-1:0]   rid;
        logic [2*DATA_W-1:0] rdata;
        logic [TW-1:0]       s_arid;
        logic [ADDR_W-1:0]   s_araddr;
        logic [LEN_W-1:0]    s_arlen;
        logic [2:0]          s_arsize;
        logic [1:0]          s_arburst;
        logic                s_arvalid;
        logic                s_rready;
        logic                perr;
    } obs_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    obs_t last_obs;

    // reference model: who owns the bus, which phase, beats still owed
    int            own;        // -1 = bus free
    bit            in_data;
    int            remaining;
    logic [TW-1:0] tag;
    int            pref;
    bit            err;

    // stimulus agent
    bit                rnd, gen_en;
    bit                pend   [2];
    int                delta  [2];
    logic [TW-1:0]     rxor   [2];
    logic [DATA_W-1:0] base   [2];
    int                rr_mode[2];   // 0 always ready, 1 toggle, 2 random
    int                beat_idx, plan;
    logic [DATA_W-1:0] s_base;
    logic [TW-1:0]     s_xor;

    // observation logs
    logic [TW-1:0]     ar_log[$];
    int                ar_cyc[$];
    logic [DATA_W-1:0] got0[$], got1[$];
    int                rlast_cyc[2];

    task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.arready   = {m1_arready, m0_arready};
        o.rvalid    = {m1_rvalid, m0_rvalid};
        o.rlast     = {m1_rlast, m0_rlast};
        o.rresp     = {m1_rresp, m0_rresp};
        o.rid       = {m1_rid, m0_rid};
        o.rdata     = {m1_rdata, m0_rdata};
        o.s_arid    = s_arid;
        o.s_araddr  = s_araddr;
        o.s_arlen   = s_arlen;
        o.s_arsize  = s_arsize;
        o.s_arburst = s_arburst;
        o.s_arvalid = s_arvalid;
        o.s_rready  = s_rready;
        o.perr      = perr;
        return o;
    endfunction

    function automatic obs_t expect_now();
        obs_t e = '0;
        if (own >= 0 && !in_data) begin
            e.s_arvalid    = m_arvalid[own];
            e.s_arid       = {3'b000, own[0], m_arid[own]};
            e.s_araddr     = m_araddr[own];
            e.s_arlen      = m_arlen[own];
            e.s_arsize     = m_arsize[own];
            e.s_arburst    = m_arburst[own];
            e.arready[own] = s_arready;
        end else if (own >= 0) begin
            e.s_rready                    = m_rready[own];
            e.rvalid[own]                 = s_rvalid;
            e.rlast[own]                  = s_rlast;
            e.rresp[own*2 +: 2]           = s_rresp;
            e.rid[own*ID_W +: ID_W]       = s_rid[ID_W-1:0];
            e.rdata[own*DATA_W +: DATA_W] = s_rdata;
        end
        e.perr = err;
        return e;
    endfunction

    task automatic request(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len, input int d, input logic [TW-1:0] x,
                           input logic [DATA_W-1:0] b);
        pend[m]      = 1'b1;
        m_arid[m]    = id;
        m_araddr[m]  = addr;
        m_arlen[m]   = len;
        m_arsize[m]  = 3'($urandom);
        m_arburst[m] = 2'($urandom);
        delta[m]     = d;
        rxor[m]      = x;
        base[m]      = b;
    endtask

    task automatic drive_inputs();
        for (int m = 0; m < 2; m++) begin
            if (rnd && gen_en && !pend[m] && $urandom_range(3) == 0) begin
                int r = int'($urandom_range(15));
                request(m, ID_W'($urandom), $urandom, LEN_W'($urandom),
                        (r == 0) ? -1 : ((r == 1) ? 1 : 0),
                        ($urandom_range(15) == 0) ? (TW'(1) << $urandom_range(TW-1)) : TW'(0),
                        $urandom);
            end
            m_arvalid[m] = pend[m];
            case (rr_mode[m])
                0:       m_rready[m] = 1'b1;
                1:       m_rready[m] = 1'(cyc & 1);
                default: m_rready[m] = 1'($urandom);
            endcase
        end
        s_arready = rnd ? 1'($urandom) : 1'b1;
        if (own >= 0 && in_data) begin
            s_rvalid = rnd ? 1'($urandom) : 1'b1;
            s_rlast  = (beat_idx == plan - 1);
            s_rdata  = s_base + DATA_W'(beat_idx);
            s_rid    = tag ^ s_xor;
            s_rresp  = 2'(beat_idx);
        end else begin
            // junk on the R channel while no read is outstanding
            s_rvalid = rnd ? 1'($urandom) : 1'b0;
            s_rlast  = 1'($urandom);
            s_rdata  = $urandom;
            s_rid    = TW'($urandom);
            s_rresp  = 2'($urandom);
        end
    endtask

    task automatic model_advance();
        if (own < 0) begin
            if (m_arvalid[0] || m_arvalid[1]) begin
                own     = (m_arvalid[0] && m_arvalid[1]) ? pref : (m_arvalid[1] ? 1 : 0);
                in_data = 1'b0;
            end
        end else if (!in_data) begin
            if (m_arvalid[own] && s_arready) begin
                tag       = {3'b000, own[0], m_arid[own]};
                remaining = int'(m_arlen[own]) + 1;
                in_data   = 1'b1;
                pend[own] = 1'b0;
                plan      = remaining + delta[own];
                if (plan < 1) plan = 1;
                beat_idx  = 0;
                s_base    = base[own];
                s_xor     = rxor[own];
            end
        end else if (s_rvalid && m_rready[own]) begin
            if ((s_rlast && remaining > 1) || (!s_rlast && remaining <= 1) || (s_rid != tag))
                err = 1'b1;
            if (remaining > 0) remaining--;
            beat_idx++;
            if (s_rlast) begin
                pref    = 1 - own;
                own     = -1;
                in_data = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        drive_inputs();
        #1;
        last_obs = sample();
        check($sformatf("cyc%0d outputs", cyc), 160'(last_obs), 160'(expect_now()));
        if (last_obs.s_arvalid && s_arready) begin
            ar_log.push_back(last_obs.s_arid);
            ar_cyc.push_back(cyc);
        end
        for (int m = 0; m < 2; m++) begin
            if (last_obs.rvalid[m] && m_rready[m]) begin
                if (m == 0) got0.push_back(last_obs.rdata[0 +: DATA_W]);
                else        got1.push_back(last_obs.rdata[DATA_W +: DATA_W]);
                if (last_obs.rlast[m]) rlast_cyc[m] = cyc;
            end
        end
        model_advance();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic clear_all();
        rnd = 1'b0; gen_en = 1'b0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; delta[m] = 0; rxor[m] = '0; base[m] = '0; rr_mode[m] = 0;
            m_arvalid[m] = 1'b0; m_arid[m] = '0; m_araddr[m] = '0; m_arlen[m] = '0;
            m_arsize[m] = '0; m_arburst[m] = '0; m_rready[m] = 1'b0;
        end
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        own = -1; in_data = 1'b0; remaining = 0; tag = '0; pref = 0; err = 1'b0;
        beat_idx = 0; plan = 0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        clear_all();
        @(posedge ACLK);
        #1;
        check("reset outputs", 160'(sample()), 160'(0));
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((own >= 0 || pend[0] || pend[1]) && k < budget) begin
            cycle();
            k++;
        end
        check({name, " completion within budget"}, 160'(own >= 0 || pend[0] || pend[1]), 160'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        clear_all();

        // 1: M0 alone, LEN=0, one beat
        do_reset();
        request(0, 4'h5, 32'h1000, 4'd0, 0, '0, 32'hDEADBEEF);
        cycle();
        check("t1 no S_ARVALID in request cycle", 160'(last_obs.s_arvalid), 160'(0));
        cycle();
        check("t1 S_ARVALID", 160'(last_obs.s_arvalid), 160'(1));
        check("t1 S_ARID", 160'(last_obs.s_arid), 160'(8'h05));
        check("t1 S_ARADDR", 160'(last_obs.s_araddr), 160'(32'h1000));
        cycle();
        check("t1 M0_RVALID", 160'(last_obs.rvalid[0]), 160'(1));
        check("t1 M0_RDATA", 160'(last_obs.rdata[0 +: DATA_W]), 160'(32'hDEADBEEF));
        check("t1 M0_RLAST", 160'(last_obs.rlast[0]), 160'(1));
        cycle();
        check("t1 idle 3 cycles after request", 160'(last_obs), 160'(0));

        // 2: simultaneous requests, round-robin
        do_reset();
        ar_log.delete();
        request(0, 4'h1, 32'h2000, 4'd1, 0, '0, 32'h10);
        request(1, 4'h2, 32'h3000, 4'd0, 0, '0, 32'h20);
        wait_idle(50, "t2 first pair");
        request(0, 4'h3, 32'h2100, 4'd0, 0, '0, 32'h30);
        request(1, 4'h4, 32'h3100, 4'd2, 0, '0, 32'h40);
        wait_idle(50, "t2 second pair");
        check("t2 grant count", 160'(ar_log.size()), 160'(4));
        if (ar_log.size() == 4) begin
            check("t2 first grant M0", 160'(ar_log[0][ID_W]), 160'(0));
            check("t2 second grant M1", 160'(ar_log[1][ID_W]), 160'(1));
            check("t2 third grant M0", 160'(ar_log[2][ID_W]), 160'(0));
            check("t2 fourth grant M1", 160'(ar_log[3][ID_W]), 160'(1));
        end

        // 3: M1 LEN=3 with toggling RREADY, M0 waits behind it
        got1.delete();
        rr_mode[1] = 1;
        request(1, 4'h3, 32'h4000, 4'd3, 0, '0, 32'h100);
        for (int k = 0; k < 20 && !(own == 1 && in_data); k++) cycle();
        request(0, 4'h7, 32'h5000, 4'd0, 0, '0, 32'h700);
        wait_idle(100, "t3");
        check("t3 beat count", 160'(got1.size()), 160'(4));
        for (int i = 0; i < 4 && i < got1.size(); i++)
            check($sformatf("t3 beat %0d data", i), 160'(got1[i]), 160'(32'h100 + i));
        check("t3 M0 grant after RLAST", 160'(ar_cyc[$] - rlast_cyc[1]), 160'(2));
        check("t3 last grant is M0", 160'(ar_log[$][ID_W]), 160'(0));

        // 4: early RLAST on a LEN=3 burst
        got0.delete();
        rr_mode[1] = 0;
        request(0, 4'h2, 32'h6000, 4'd3, -1, '0, 32'h200);
        wait_idle(50, "t4 short burst");
        cycle();
        check("t4 protocol_err set", 160'(last_obs.perr), 160'(1));
        check("t4 beats delivered", 160'(got0.size()), 160'(3));
        repeat (3) cycle();
        check("t4 protocol_err sticky", 160'(last_obs.perr), 160'(1));
        got1.delete();
        request(1, 4'h4, 32'h7000, 4'd1, 0, '0, 32'h300);
        wait_idle(50, "t4 clean follow-up");
        check("t4 follow-up beats", 160'(got1.size()), 160'(2));
        if (got1.size() == 2) check("t4 follow-up last beat", 160'(got1[1]), 160'(32'h301));

        // 5: returned ID carries the other master's grant bit
        do_reset();
        request(0, 4'h6, 32'h8000, 4'd0, 0, TW'(1 << ID_W), 32'h500);
        wait_idle(50, "t5");
        cycle();
        check("t5 ID mismatch flagged", 160'(last_obs.perr), 160'(1));

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        request(1, 4'h9, 32'h9000, 4'd7, 0, '0, 32'h900);
        for (int k = 0; k < 20 && !(own == 1 && in_data); k++) cycle();
        repeat (2) cycle();
        ARESETn = 1'b0;
        #1;
        check("t6 outputs during async reset", 160'(sample()), 160'(0));
        clear_all();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        ar_log.delete();
        got1.delete();
        request(1, 4'hA, 32'hA000, 4'd0, 0, '0, 32'h600);
        wait_idle(50, "t6 after reset");
        check("t6 grant count", 160'(ar_log.size()), 160'(1));
        if (ar_log.size() == 1) check("t6 S_ARID", 160'(ar_log[0]), 160'(8'h1A));
        check("t6 data beats", 160'(got1.size()), 160'(1));
        if (got1.size() == 1) check("t6 data", 160'(got1[0]), 160'(32'h600));

        // 7: randomized traffic against the model
        do_reset();
        rnd = 1'b1;
        gen_en = 1'b1;
        rr_mode[0] = 2;
        rr_mode[1] = 2;
        repeat (3000) cycle();
        gen_en = 1'b0;
        wait_idle(1000, "t7 drain");
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
